// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard control: stall/flush enables, E-stage forwarding selects, memory-wait FSM with timeout.
// Optional performance counters are built when PERF_COUNTERS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int PERF_W         = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  load_e,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  pc_src_e,
  input  logic                  mem_req_m,
  input  logic                  mem_ack,
  output logic                  en_f,
  output logic                  en_d,
  output logic                  en_e,
  output logic                  en_m,
  output logic                  en_w,
  output logic                  clr_d,
  output logic                  clr_e,
  output logic                  clr_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  mem_timeout,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_events
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_count;
  logic             mem_stall;
  logic             lw_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_count  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req_m && !mem_ack) begin
            state      <= WAIT;
            wait_count <= '0;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            state <= IDLE;
          end else if (wait_count == CNT_LAST) begin
            state       <= ERROR;
            mem_timeout <= 1'b1;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        ERROR:   mem_timeout <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // M-stage result is the youngest, so it wins over W for the same register.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (reg_write_m && rd_m != '0 && rd_m == src)      fwd_sel = 2'b10;
    else if (reg_write_w && rd_w != '0 && rd_w == src) fwd_sel = 2'b01;
    else                                                fwd_sel = 2'b00;
  endfunction

  always_comb begin
    case (state)
      IDLE:    mem_stall = mem_req_m && !mem_ack;
      WAIT:    mem_stall = !mem_ack;
      default: mem_stall = 1'b1;
    endcase
  end

  assign lw_stall = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);

  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_e    = 1'b1;
    en_m    = 1'b1;
    en_w    = 1'b1;
    clr_d   = 1'b0;
    clr_e   = 1'b0;
    clr_w   = 1'b0;
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (reset_n) begin
      fwd_a_e = fwd_sel(rs1_e);
      fwd_b_e = fwd_sel(rs2_e);
      // A frozen E keeps its branch/load, so those hazards are handled on release.
      if (mem_stall) begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        en_e  = 1'b0;
        en_m  = 1'b0;
        clr_w = 1'b1;
      end else if (pc_src_e) begin
        clr_d = 1'b1;
        clr_e = 1'b1;
      end else if (lw_stall) begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        clr_e = 1'b1;
      end
    end
  end

`ifdef PERF_COUNTERS_EN
  logic any_stall;
  logic any_flush;

  assign any_stall = !(en_f && en_d && en_e && en_m);
  assign any_flush = clr_d || clr_e;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (any_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (any_flush && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (TIMEOUT_CYCLES=4); counter checks follow PERF_COUNTERS_EN.
module tb_pipeline_hazard_ctrl;

  logic        clock;
  logic        reset_n;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ack;
  logic        en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  typedef struct {
    logic       rstn;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, rwm, rww, pc_src, req, ack;
  } stim_t;

  typedef struct {
    string       name;
    logic [4:0]  en;
    logic [2:0]  clr;
    logic [1:0]  fa, fb;
    logic        to;
    logic [31:0] stall, flush;
  } exp_t;

  exp_t        expQ[$];
  int          checkCount = 0;
  int          failCount  = 0;
  logic [31:0] modelStall = 0;
  logic [31:0] modelFlush = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .TIMEOUT_CYCLES(4), .PERF_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .clr_d(clr_d), .clr_e(clr_e), .clr_w(clr_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic stim_t idle();
    stim_t s;
    s.rstn = 1'b1;
    s.rs1_d = 0; s.rs2_d = 0; s.rs1_e = 0; s.rs2_e = 0;
    s.rd_e = 0; s.rd_m = 0; s.rd_w = 0;
    s.load_e = 0; s.rwm = 0; s.rww = 0; s.pc_src = 0; s.req = 0; s.ack = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset_n = s.rstn;
    rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
    rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
    load_e = s.load_e; reg_write_m = s.rwm; reg_write_w = s.rww;
    pc_src_e = s.pc_src; mem_req_m = s.req; mem_ack = s.ack;
  endtask

  // Drives one cycle of inputs and queues the hand-computed response.
  // en is {f,d,e,m,w}; clr is {d,e,w}; counter expectations are the totals of earlier cycles.
  task automatic applyStimulus(input stim_t s, input string name, input logic [4:0] en,
                               input logic [2:0] clr, input logic [1:0] fa, input logic [1:0] fb,
                               input logic to);
    exp_t e;
    @(posedge clock);
    #1;
    drive(s);
    if (!s.rstn) begin
      modelStall = 0;
      modelFlush = 0;
    end
    e.name = name; e.en = en; e.clr = clr; e.fa = fa; e.fb = fb; e.to = to;
`ifdef PERF_COUNTERS_EN
    e.stall = modelStall;
    e.flush = modelFlush;
`else
    e.stall = 0;
    e.flush = 0;
`endif
    expQ.push_back(e);
    if (s.rstn && en[4:1] != 4'hF) modelStall = modelStall + 1;
    if (s.rstn && (clr[2] || clr[1])) modelFlush = modelFlush + 1;
  endtask

  task automatic compare(input string name, input string field, input logic [31:0] act,
                         input logic [31:0] want);
    checkCount++;
    if (act !== want) begin
      failCount++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compare(e.name, "en", {27'd0, en_f, en_d, en_e, en_m, en_w}, {27'd0, e.en});
    compare(e.name, "clr", {29'd0, clr_d, clr_e, clr_w}, {29'd0, e.clr});
    compare(e.name, "fwd_a", {30'd0, fwd_a_e}, {30'd0, e.fa});
    compare(e.name, "fwd_b", {30'd0, fwd_b_e}, {30'd0, e.fb});
    compare(e.name, "timeout", {31'd0, mem_timeout}, {31'd0, e.to});
    compare(e.name, "stall_cycles", stall_cycles, e.stall);
    compare(e.name, "flush_events", flush_events, e.flush);
  endtask

  // Monitor: outputs are combinational, so each queued cycle is sampled at its falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rstn = 1'b0;
    drive(s);

    s = idle(); s.rstn = 0; s.rwm = 1; s.rd_m = 5; s.rs1_e = 5; s.load_e = 1; s.rd_e = 7;
    s.rs2_d = 7; s.pc_src = 1; s.req = 1;
    applyStimulus(s, "in_reset", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    applyStimulus(idle(), "idle", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

    s = idle(); s.rwm = 1; s.rd_m = 5; s.rww = 1; s.rd_w = 5; s.rs1_e = 5; s.rs2_e = 3;
    applyStimulus(s, "fwd_m", 5'b11111, 3'b000, 2'b10, 2'b00, 0);
    s.rd_m = 0;
    applyStimulus(s, "fwd_w", 5'b11111, 3'b000, 2'b01, 2'b00, 0);
    s.rd_w = 0;
    applyStimulus(s, "fwd_none", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    s = idle(); s.rwm = 1; s.rd_m = 6; s.rww = 1; s.rd_w = 5; s.rs1_e = 6; s.rs2_e = 5;
    applyStimulus(s, "fwd_mix", 5'b11111, 3'b000, 2'b10, 2'b01, 0);
    s = idle(); s.rwm = 0; s.rd_m = 5; s.rww = 1; s.rd_w = 5; s.rs1_e = 5; s.rs2_e = 5;
    applyStimulus(s, "fwd_nowrite_m", 5'b11111, 3'b000, 2'b01, 2'b01, 0);

    s = idle(); s.load_e = 1; s.rd_e = 7; s.rs2_d = 7;
    applyStimulus(s, "load_use", 5'b00111, 3'b010, 2'b00, 2'b00, 0);
    applyStimulus(idle(), "load_release", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    s = idle(); s.load_e = 1; s.rd_e = 0; s.rs1_d = 0;
    applyStimulus(s, "load_x0", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    s = idle(); s.pc_src = 1; s.load_e = 1; s.rd_e = 7; s.rs1_d = 7;
    applyStimulus(s, "branch_load", 5'b11111, 3'b110, 2'b00, 2'b00, 0);

    s = idle(); s.req = 1;
    applyStimulus(s, "mem_w1", 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    applyStimulus(s, "mem_w2", 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    s.pc_src = 1; s.load_e = 1; s.rd_e = 7; s.rs1_d = 7;
    applyStimulus(s, "mem_w3_branch", 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    s = idle(); s.req = 1; s.ack = 1; s.pc_src = 1;
    applyStimulus(s, "mem_ack_branch", 5'b11111, 3'b110, 2'b00, 2'b00, 0);
    s = idle(); s.req = 1; s.ack = 1;
    applyStimulus(s, "zero_wait", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    s.ack = 0;
    applyStimulus(s, "new_req", 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    s.ack = 1;
    applyStimulus(s, "new_ack", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

    s = idle(); s.req = 1;
    for (int i = 1; i <= 5; i++)
      applyStimulus(s, $sformatf("to_wait%0d", i), 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    applyStimulus(s, "to_err1", 5'b00001, 3'b001, 2'b00, 2'b00, 1);
    applyStimulus(s, "to_err2", 5'b00001, 3'b001, 2'b00, 2'b00, 1);
    s = idle(); s.ack = 1;
    applyStimulus(s, "to_err_ack", 5'b00001, 3'b001, 2'b00, 2'b00, 1);
    s = idle(); s.rstn = 0; s.req = 1;
    applyStimulus(s, "to_reset", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    applyStimulus(idle(), "post_reset", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    s = idle(); s.req = 1;
    applyStimulus(s, "post_req", 5'b00001, 3'b001, 2'b00, 2'b00, 0);
    s.ack = 1;
    applyStimulus(s, "post_ack", 5'b11111, 3'b000, 2'b00, 2'b00, 0);
    applyStimulus(idle(), "final", 5'b11111, 3'b000, 2'b00, 2'b00, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clock);
    if (expQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
